line_pattern_gen: RTL and testbench

LINE_PATTERN_GEN -- requirements
Module: line_pattern_gen

---
 rtl/video_pkg.sv | 39 +++
 rtl/pattern_color.sv | 29 ++
 rtl/line_pattern_gen.sv | 151 +++++++++++++++
 tb/tb_line_pattern_gen.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: resolution default, pattern mode encodings and the
// fixed colours used by the line pattern generator.
package video_pkg;

  localparam int H_RES_DEF = 800;
  localparam int ADDR_W    = 10;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  localparam logic [23:0] CHECK_ON  = 24'hEEEEEE;
  localparam logic [23:0] CHECK_OFF = 24'h444444;

  // Standard 8-bar order, brightest first
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pattern_color.sv
// Combinational pixel colour for one (x, y) position in the selected pattern.
module pattern_color
  import video_pkg::*;
#(
  parameter int CHECK_SHIFT = 4
) (
  input  mode_e       mode_i,
  input  logic [9:0]  x_i,
  input  logic [9:0]  y_i,
  input  logic [2:0]  bar_idx_i,
  input  logic [23:0] solid_i,
  output logic [23:0] rgb_o
);

  logic unused_bits;
  assign unused_bits = ^{x_i[1:0], y_i};

  always_comb begin
    rgb_o = '0;
    case (mode_i)
      MODE_SOLID: rgb_o = solid_i;
      MODE_CHECK: rgb_o = (x_i[CHECK_SHIFT] ^ y_i[CHECK_SHIFT]) ? CHECK_ON : CHECK_OFF;
      MODE_BARS:  rgb_o = bar_color(bar_idx_i);
      MODE_GRAD:  rgb_o = {x_i[9:2], x_i[9:2], x_i[9:2]};
      default:    rgb_o = '0;
    endcase
  end

endmodule

// File: rtl/line_pattern_gen.sv
// Fills one H_RES-pixel line per request into a line buffer; a one-deep pending
// slot lets consecutive lines stream with no idle cycle between them.
//   state   | meaning
//   ST_IDLE | no line in progress, waiting for line_request
//   ST_FILL | writing pixels, one per cycle
module line_pattern_gen
  import video_pkg::*;
#(
  parameter int H_RES       = H_RES_DEF,
  parameter int CHECK_SHIFT = 4,
  parameter int BAR_W       = 100
) (
  input  logic        clk_psram,
  input  logic        rst,
  input  logic        line_request,
  input  logic [9:0]  y_pos,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  input  logic        clr_overrun,
  output logic [9:0]  wr_addr,
  output logic [23:0] wr_data,
  output logic        wr_en,
  output logic        busy,
  output logic        overrun
);

  state_e      state_q, state_d;
  logic [9:0]  y_q, y_d, pend_y_q, pend_y_d;
  mode_e       mode_q, mode_d;
  logic [23:0] solid_q, solid_d;
  logic        pend_q, pend_d, overrun_q, overrun_d;
  logic [9:0]  bar_cnt_q, bar_cnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [9:0]  wr_addr_q, x_d;
  logic [23:0] wr_data_q, pix_rgb;
  logic        wr_en_q, wr_en_d;
  logic        start, last;
  logic [9:0]  start_y;

  assign last = (wr_addr_q == ADDR_W'(H_RES - 1));

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pend_y_d  = pend_y_q;
    overrun_d = overrun_q & ~clr_overrun;
    y_d       = y_q;
    mode_d    = mode_q;
    solid_d   = solid_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    x_d       = '0;
    wr_en_d   = 1'b0;
    start     = 1'b0;
    start_y   = y_pos;
    case (state_q)
      ST_IDLE: start = line_request;
      ST_FILL: begin
        if (last) begin
          // The pending line starts now; a request on this same cycle takes the freed slot
          if (pend_q) begin
            start    = 1'b1;
            start_y  = pend_y_q;
            pend_d   = line_request;
            pend_y_d = y_pos;
          end else if (line_request) begin
            start = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          wr_en_d = 1'b1;
          x_d     = wr_addr_q + 10'd1;
          if (bar_cnt_q == ADDR_W'(BAR_W - 1)) begin
            bar_cnt_d = '0;
            if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
          end else begin
            bar_cnt_d = bar_cnt_q + 10'd1;
          end
          if (line_request) begin
            if (pend_q) begin
              overrun_d = 1'b1;
            end else begin
              pend_d   = 1'b1;
              pend_y_d = y_pos;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d   = ST_FILL;
      wr_en_d   = 1'b1;
      x_d       = '0;
      bar_cnt_d = '0;
      bar_idx_d = '0;
      y_d       = start_y;
      mode_d    = mode_e'(mode);
      solid_d   = solid_rgb;
    end
  end

  pattern_color #(
    .CHECK_SHIFT(CHECK_SHIFT)
  ) u_color (
    .mode_i   (mode_d),
    .x_i      (x_d),
    .y_i      (y_d),
    .bar_idx_i(bar_idx_d),
    .solid_i  (solid_d),
    .rgb_o    (pix_rgb)
  );

  always_ff @(posedge clk_psram or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pend_q    <= 1'b0;
      pend_y_q  <= '0;
      overrun_q <= 1'b0;
      y_q       <= '0;
      mode_q    <= MODE_SOLID;
      solid_q   <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pend_y_q  <= pend_y_d;
      overrun_q <= overrun_d;
      y_q       <= y_d;
      mode_q    <= mode_d;
      solid_q   <= solid_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      wr_addr_q <= x_d;
      wr_data_q <= wr_en_d ? pix_rgb : '0;
      wr_en_q   <= wr_en_d;
    end
  end

  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_en   = wr_en_q;
  assign busy    = (state_q == ST_FILL);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_line_pattern_gen.sv
// Self-checking bench for line_pattern_gen: captures every write and compares it
// against an arithmetic model of the patterns.
module tb_line_pattern_gen;

  localparam int H_RES = 800;
  localparam int CS    = 4;
  localparam int BAR_W = 100;

  logic        clk_psram = 1'b0;
  logic        rst = 1'b1;
  logic        line_request = 1'b0;
  logic [9:0]  y_pos = '0;
  logic [1:0]  mode = '0;
  logic [23:0] solid_rgb = '0;
  logic        clr_overrun = 1'b0;
  logic [9:0]  wr_addr;
  logic [23:0] wr_data;
  logic        wr_en, busy, overrun;

  line_pattern_gen #(.H_RES(H_RES), .CHECK_SHIFT(CS), .BAR_W(BAR_W)) dut (
    .clk_psram   (clk_psram),
    .rst         (rst),
    .line_request(line_request),
    .y_pos       (y_pos),
    .mode        (mode),
    .solid_rgb   (solid_rgb),
    .clr_overrun (clr_overrun),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk_psram = ~clk_psram;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk_psram) cyc <= cyc + 1;

  int          cap_addr[$];
  logic [23:0] cap_data[$];
  int          cap_cyc[$];
  int          exp_y[$];
  int          exp_m[$];
  logic [23:0] exp_s[$];

  always @(negedge clk_psram) begin
    if (wr_en === 1'b1) begin
      cap_addr.push_back(int'(wr_addr));
      cap_data.push_back(wr_data);
      cap_cyc.push_back(cyc);
    end
  end

  function automatic logic [23:0] model_pix(input int m, input int x, input int y, input logic [23:0] s);
    int idx;
    int g;
    logic [23:0] c;
    c = 24'h0;
    case (m)
      0: c = s;
      1: c = ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? 24'hEEEEEE : 24'h444444;
      2: begin
        idx = x / BAR_W;
        if (idx > 7) idx = 7;
        case (idx)
          0: c = 24'hFFFFFF;
          1: c = 24'hFFFF00;
          2: c = 24'h00FFFF;
          3: c = 24'h00FF00;
          4: c = 24'hFF00FF;
          5: c = 24'hFF0000;
          6: c = 24'h0000FF;
          default: c = 24'h000000;
        endcase
      end
      default: begin
        g = (x >> 2) & 255;
        c = {g[7:0], g[7:0], g[7:0]};
      end
    endcase
    return c;
  endfunction

  // Index of the first captured write that disagrees with the expected lines, or -1
  function automatic int first_bad();
    for (int i = 0; i < cap_addr.size(); i++) begin
      int ln;
      int x;
      ln = i / H_RES;
      x  = i % H_RES;
      if (ln >= exp_y.size()) return i;
      if (cap_addr[i] != x) return i;
      if (cap_data[i] !== model_pix(exp_m[ln], x, exp_y[ln], exp_s[ln])) return i;
    end
    return -1;
  endfunction

  function automatic int first_gap();
    for (int i = 1; i < cap_cyc.size(); i++)
      if (cap_cyc[i] != cap_cyc[i-1] + 1) return i;
    return -1;
  endfunction

  task automatic clear_cap();
    cap_addr.delete(); cap_data.delete(); cap_cyc.delete();
    exp_y.delete(); exp_m.delete(); exp_s.delete();
  endtask

  task automatic expect_line(input int y, input int m, input logic [23:0] s);
    exp_y.push_back(y); exp_m.push_back(m); exp_s.push_back(s);
  endtask

  task automatic send_req(input logic [9:0] y, input logic [1:0] m, input logic [23:0] s);
    line_request = 1'b1;
    y_pos = y; mode = m; solid_rgb = s;
    @(posedge clk_psram); #1;
    line_request = 1'b0;
  endtask

  task automatic wait_addr(input int a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk_psram);
      if (wr_en === 1'b1 && int'(wr_addr) == a) ok = 1'b1;
    end
  endtask

  task automatic wait_done(output bit ok, output int done_cyc);
    ok = 1'b0;
    done_cyc = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk_psram);
      if (busy === 1'b0 && wr_en === 1'b0) begin
        ok = 1'b1;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_psram);
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (wr_addr !== 10'd0) begin n_bad++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
    n_cmp++; if (wr_data !== 24'd0) begin n_bad++; $display("FAIL rst_wr_data: got %h want 0", wr_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    @(posedge clk_psram); #1 rst = 1'b0;
    clear_cap();
    repeat (10) @(negedge clk_psram);
    n_cmp++; if (cap_addr.size() != 0) begin n_bad++; $display("FAIL rst_no_write: got %0d writes want 0", cap_addr.size()); end
  endtask

  task automatic test_checker();
    bit ok; int done_c; int req_c; int b;
    clear_cap();
    @(negedge clk_psram);
    send_req(10'd0, 2'd1, 24'h0);
    req_c = cyc;
    expect_line(0, 1, 24'h0);
    wait_done(ok, done_c);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL chk_timeout: line did not finish"); end
    n_cmp++; if (cap_addr.size() != H_RES) begin n_bad++; $display("FAIL chk_count: got %0d want %0d", cap_addr.size(), H_RES); end
    b = first_bad();
    n_cmp++; if (b != -1) begin n_bad++; $display("FAIL chk_data: first bad write index %0d want none", b); end
    n_cmp++; if (first_gap() != -1) begin n_bad++; $display("FAIL chk_gap: gap at index %0d want none", first_gap()); end
    if (cap_addr.size() >= 32) begin
      n_cmp++; if (cap_cyc[0] != req_c) begin n_bad++; $display("FAIL chk_latency: first write cycle %0d want %0d", cap_cyc[0], req_c); end
      n_cmp++; if (cap_data[15] !== 24'h444444) begin n_bad++; $display("FAIL chk_px15: got %h want 444444", cap_data[15]); end
      n_cmp++; if (cap_data[16] !== 24'hEEEEEE) begin n_bad++; $display("FAIL chk_px16: got %h want eeeeee", cap_data[16]); end
      n_cmp++; if (done_c != cap_cyc[cap_cyc.size()-1] + 1) begin n_bad++; $display("FAIL chk_idle_after: idle at cycle %0d want %0d", done_c, cap_cyc[cap_cyc.size()-1] + 1); end
    end
  endtask

  task automatic test_random_lines();
    bit ok; int done_c; int b;
    logic [9:0] y; logic [1:0] m; logic [23:0] s;
    for (int k = 0; k < 6; k++) begin
      clear_cap();
      y = 10'($urandom_range(0, 1023));
      m = 2'($urandom_range(0, 3));
      s = 24'($urandom);
      repeat ($urandom_range(1, 5)) @(negedge clk_psram);
      send_req(y, m, s);
      expect_line(int'(y), int'(m), s);
      y_pos = 10'($urandom); mode = 2'($urandom); solid_rgb = 24'($urandom);
      wait_done(ok, done_c);
      n_cmp++; if (!ok || cap_addr.size() != H_RES) begin n_bad++; $display("FAIL rnd_count[%0d]: got %0d writes (done=%b) want %0d", k, cap_addr.size(), ok, H_RES); end
      b = first_bad();
      n_cmp++; if (b != -1) begin n_bad++; $display("FAIL rnd_data[%0d] mode %0d y %0d: first bad index %0d want none", k, m, y, b); end
    end
  endtask

  task automatic test_bars();
    bit ok; int done_c; int b;
    clear_cap();
    @(negedge clk_psram);
    send_req(10'd0, 2'd2, 24'h0);
    expect_line(0, 2, 24'h0);
    wait_done(ok, done_c);
    n_cmp++; if (!ok || cap_addr.size() != H_RES) begin n_bad++; $display("FAIL bar_count: got %0d want %0d", cap_addr.size(), H_RES); end
    if (cap_addr.size() == H_RES) begin
      n_cmp++; if (cap_data[99] !== 24'hFFFFFF) begin n_bad++; $display("FAIL bar_px99: got %h want ffffff", cap_data[99]); end
      n_cmp++; if (cap_data[100] !== 24'hFFFF00) begin n_bad++; $display("FAIL bar_px100: got %h want ffff00", cap_data[100]); end
      n_cmp++; if (cap_data[799] !== 24'h000000) begin n_bad++; $display("FAIL bar_px799: got %h want 000000", cap_data[799]); end
    end
    b = first_bad();
    n_cmp++; if (b != -1) begin n_bad++; $display("FAIL bar_data: first bad index %0d want none", b); end
  endtask

  task automatic test_back_to_back(input int at_addr, input int y2);
    bit ok; int done_c; int b;
    clear_cap();
    @(negedge clk_psram);
    send_req(10'd0, 2'd1, 24'h0);
    expect_line(0, 1, 24'h0);
    wait_addr(at_addr, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_wait[%0d]: address never seen", at_addr); end
    send_req(10'(y2), 2'd1, 24'h0);
    expect_line(y2, 1, 24'h0);
    y_pos = 10'd5;
    wait_done(ok, done_c);
    n_cmp++; if (!ok || cap_addr.size() != 2 * H_RES) begin n_bad++; $display("FAIL b2b_count[%0d]: got %0d want %0d", at_addr, cap_addr.size(), 2 * H_RES); end
    b = first_bad();
    n_cmp++; if (b != -1) begin n_bad++; $display("FAIL b2b_data[%0d]: first bad index %0d want none", at_addr, b); end
    n_cmp++; if (first_gap() != -1) begin n_bad++; $display("FAIL b2b_gap[%0d]: gap at index %0d want none", at_addr, first_gap()); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun[%0d]: got %b want 0", at_addr, overrun); end
  endtask

  task automatic test_overrun();
    bit ok; int done_c; int b;
    clear_cap();
    @(negedge clk_psram);
    send_req(10'd0, 2'd1, 24'h0);
    expect_line(0, 1, 24'h0);
    wait_addr(100, ok);
    send_req(10'd16, 2'd1, 24'h0);
    expect_line(16, 1, 24'h0);
    y_pos = 10'd7;
    wait_addr(200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovr_wait: address 200 never seen"); end
    clr_overrun = 1'b1;
    send_req(10'd3, 2'd1, 24'h0);
    clr_overrun = 1'b0;
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_clr_same_cycle: got %b want 1", overrun); end
    wait_done(ok, done_c);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    n_cmp++; if (!ok || cap_addr.size() != 2 * H_RES) begin n_bad++; $display("FAIL ovr_count: got %0d want %0d", cap_addr.size(), 2 * H_RES); end
    b = first_bad();
    n_cmp++; if (b != -1) begin n_bad++; $display("FAIL ovr_data: first bad index %0d want none", b); end
    @(negedge clk_psram); clr_overrun = 1'b1;
    @(posedge clk_psram); #1 clr_overrun = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b want 0", overrun); end
  endtask

  task automatic test_mode_latch();
    bit ok; int done_c; int b;
    clear_cap();
    @(negedge clk_psram);
    send_req(10'd0, 2'd0, 24'h123456);
    expect_line(0, 0, 24'h123456);
    wait_addr(400, ok);
    mode = 2'd1; solid_rgb = 24'hABCDEF;
    wait_done(ok, done_c);
    n_cmp++; if (!ok || cap_addr.size() != H_RES) begin n_bad++; $display("FAIL latch_count: got %0d want %0d", cap_addr.size(), H_RES); end
    b = first_bad();
    n_cmp++; if (b != -1) begin n_bad++; $display("FAIL latch_data: first bad index %0d want none", b); end
    if (cap_addr.size() == H_RES) begin
      n_cmp++; if (cap_data[799] !== 24'h123456) begin n_bad++; $display("FAIL latch_px799: got %h want 123456", cap_data[799]); end
    end
  endtask

  task automatic test_reset_midline();
    bit ok; int done_c; int req_c; int b;
    clear_cap();
    @(negedge clk_psram);
    send_req(10'd0, 2'd3, 24'h0);
    wait_addr(200, ok);
    send_req(10'd16, 2'd3, 24'h0);
    wait_addr(300, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_wait: address 300 never seen"); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rmid_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (wr_addr !== 10'd0) begin n_bad++; $display("FAIL rmid_wr_addr: got %0d want 0", wr_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    repeat (3) @(posedge clk_psram);
    #1 rst = 1'b0;
    clear_cap();
    repeat (20) @(negedge clk_psram);
    n_cmp++; if (cap_addr.size() != 0) begin n_bad++; $display("FAIL rmid_no_write: got %0d writes want 0", cap_addr.size()); end
    send_req(10'd7, 2'd3, 24'h0);
    req_c = cyc;
    expect_line(7, 3, 24'h0);
    wait_done(ok, done_c);
    n_cmp++; if (!ok || cap_addr.size() != H_RES) begin n_bad++; $display("FAIL rmid_count: got %0d want %0d", cap_addr.size(), H_RES); end
    b = first_bad();
    n_cmp++; if (b != -1) begin n_bad++; $display("FAIL rmid_data: first bad index %0d want none", b); end
    if (cap_addr.size() > 0) begin
      n_cmp++; if (cap_cyc[0] != req_c) begin n_bad++; $display("FAIL rmid_latency: first write cycle %0d want %0d", cap_cyc[0], req_c); end
    end
  endtask

  initial begin
    test_reset();
    test_checker();
    test_random_lines();
    test_bars();
    test_back_to_back(400, 16);
    test_back_to_back(799, 48);
    test_overrun();
    test_mode_latch();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
